fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Parametrised multi-byte instruction fetch/sequence unit; successor to the fixed 2-byte opcode counter.
//  Assembles INSTR_BYTES bus beats from a BUS_W-wide memory into one instruction word.
//  Owns the PC and applies relative or absolute jumps.
//  Inserts an optional load/store memory phase and stalls on a memory-ready handshake.
//  Sits between the memory bus arbiter and the op decode / register file.
// PARAMETERS
//  PC_W         16  program counter / address width
//  BUS_W        8   memory data bus width
//  INSTR_BYTES  2   bus beats per instruction (>=1)
//  JMP_W        8   width of signed relative jump offset (<=PC_W)
// PORTS
//  clk         in   1                  system clock, rising edge
//  rst         in   1                  synchronous reset, active-high
//  mem_data    in   BUS_W              read data from memory bus
//  mem_rdy     in   1                  memory beat complete this cycle
//  mem_addr    out  PC_W               address driven to memory
//  mem_rd      out  1                  fetch read request (instruction phase)
//  ls_phase    out  1                  bus owned by load/store; mem_addr = ls_addr
//  instr       out  BUS_W*INSTR_BYTES  assembled instruction, byte 0 in LSBs
//  instr_vld   out  1                  one-cycle pulse: instr complete, execute now
//  pc          out  PC_W               address of current instruction's byte 0
//  exec_ls     in   1                  instruction needs a memory phase (sampled in EXEC)
//  ls_addr     in   PC_W               load/store address (used in MEM)
//  jmp_rel_en  in   1                  take relative jump (sampled in EXEC)
//  jmp_rel     in   JMP_W              signed offset, added to pc
//  jmp_abs_en  in   1                  take absolute jump (sampled in EXEC)
//  jmp_abs     in   PC_W               absolute target
//  halt        in   1                  stop after current instruction (sampled in EXEC)
// BEHAVIOUR
//  Reset:
//   - state=FETCH, beat=0, pc=0, instr=0.
//   - instr_vld=0, ls_phase=0, mem_rd=1, mem_addr=0.
//  FETCH:
//   - mem_rd=1; mem_addr = pc + beat (mod 2^PC_W).
//   - On mem_rdy: instr[beat*BUS_W +: BUS_W] <= mem_data; beat++.
//   - On last beat: go to EXEC, beat<=0.
//  EXEC (exactly one cycle):
//   - instr_vld=1, mem_rd=0.
//   - next_pc: jmp_abs_en ? jmp_abs : jmp_rel_en ? pc+sext(jmp_rel) : pc+INSTR_BYTES.
//   - All next_pc arithmetic wraps mod 2^PC_W.
//   - pc <= next_pc at EXEC exit.
//   - Next state: halt ? HALT : exec_ls ? MEM : FETCH.
//  MEM:
//   - ls_phase=1, mem_rd=0, mem_addr=ls_addr.
//   - Hold until mem_rdy, then go to FETCH.
//  HALT: all strobes 0; pc and instr hold; exit only via rst.
//  Latency: min INSTR_BYTES+1 cycles per instruction, +1 with MEM; each mem_rdy-low cycle adds one.
//  Boundaries:
//   - mem_rdy low: stall in place; mem_addr, beat, instr and pc stable.
//   - jmp_abs_en & jmp_rel_en together: absolute wins.
//   - Jump with exec_ls: MEM runs first; fetch then resumes at the jump target.
//   - halt with exec_ls: halt wins; no MEM phase.
//   - Fetch beats past 2^PC_W-1 wrap to 0.
//   - Control inputs are ignored outside EXEC.
//   - rst mid-fetch or in MEM: partial instr discarded; no instr_vld is emitted.
// STRUCTURE
//  fetch_pkg:
//   - fetch_state_e {FETCH, EXEC, MEM, HALT}.
//   - sext_jmp() function.
//   - localparam BEAT_W = $clog2(INSTR_BYTES) (min 1).
//  Sub-module fetch_pc_next: combinational next-PC adder/mux, parameters PC_W and JMP_W.
// TESTING
//  1 Reset, mem_rdy=1, bytes 0x34, 0x12 at pc 0,1 -> instr=0x1234, instr_vld at cycle 3, pc=2.
//  2 EXEC with jmp_rel_en, jmp_rel=0xFC at pc=0x0010 -> next fetch mem_addr=0x000C.
//  3 jmp_abs_en=1, jmp_abs=0x8000 and jmp_rel_en=1 together -> next fetch at 0x8000.
//  4 exec_ls=1, ls_addr=0x9A00, mem_rdy low 3 cycles -> ls_phase high 4 cycles, then fetch at pc+2.
//  5 pc=0xFFFF, INSTR_BYTES=2 -> beats at 0xFFFF, 0x0000; next pc=0x0001.
//  6 rst asserted after beat 0 -> no instr_vld; next fetch at addr 0, instr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} fetch_state_e;

  localparam int INSTR_BYTES_DFLT = 2;

  // A beat counter needs at least one bit, even for single-beat instructions.
  function automatic int beat_w_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int BEAT_W = beat_w_of(INSTR_BYTES_DFLT);

  // Sign-extend the low jmp_w bits of raw to 32 bits.
  function automatic logic [31:0] sext_jmp(input logic [31:0] raw, input int jmp_w);
    int sh;
    sh = 32 - jmp_w;
    return 32'($signed(raw << sh) >>> sh);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory-bus and decode-side signal bundle for the fetch sequencer.
// Latency: n/a (wiring only).
// Backpressure: mem_rdy from the memory side stalls the sequencer.
// Ports: master = sequencer side, slave = memory arbiter / decode side.
interface fetch_sequencer_if #(
  parameter int PC_W        = 16,
  parameter int BUS_W       = 8,
  parameter int INSTR_BYTES = 2,
  parameter int JMP_W       = 8
) ();

  logic [BUS_W-1:0]             mem_data;
  logic                         mem_rdy;
  logic [PC_W-1:0]              mem_addr;
  logic                         mem_rd;
  logic                         ls_phase;
  logic [BUS_W*INSTR_BYTES-1:0] instr;
  logic                         instr_vld;
  logic [PC_W-1:0]              pc;
  logic                         exec_ls;
  logic [PC_W-1:0]              ls_addr;
  logic                         jmp_rel_en;
  logic [JMP_W-1:0]             jmp_rel;
  logic                         jmp_abs_en;
  logic [PC_W-1:0]              jmp_abs;
  logic                         halt;

  modport master (
    input  mem_data, mem_rdy, exec_ls, ls_addr,
    input  jmp_rel_en, jmp_rel, jmp_abs_en, jmp_abs, halt,
    output mem_addr, mem_rd, ls_phase, instr, instr_vld, pc
  );

  modport slave (
    output mem_data, mem_rdy, exec_ls, ls_addr,
    output jmp_rel_en, jmp_rel, jmp_abs_en, jmp_abs, halt,
    input  mem_addr, mem_rd, ls_phase, instr, instr_vld, pc
  );

endinterface

// File: rtl/fetch_pc_next.sv
// Next-PC selection: absolute jump, signed relative jump, or sequential step.
// Latency: combinational.
// Backpressure: none.
// Ports: pc, jmp_abs_en/jmp_abs, jmp_rel_en/jmp_rel in; next_pc out (wraps mod 2^PC_W).
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int JMP_W = 8,
  parameter int STEP  = 2
) (
  input  logic [PC_W-1:0]  pc,
  input  logic             jmp_abs_en,
  input  logic [PC_W-1:0]  jmp_abs,
  input  logic             jmp_rel_en,
  input  logic [JMP_W-1:0] jmp_rel,
  output logic [PC_W-1:0]  next_pc
);

  always_comb begin
    next_pc = pc + PC_W'(STEP);
    // Absolute has priority when both jump enables are raised.
    if (jmp_abs_en) begin
      next_pc = jmp_abs;
    end else if (jmp_rel_en) begin
      next_pc = pc + PC_W'(sext_jmp(32'(jmp_rel), JMP_W));
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-beat instruction fetch, PC ownership, jumps and an optional load/store bus phase.
// Latency: INSTR_BYTES+1 cycles per instruction, +1 with a memory phase.
// Backpressure: every cycle with mem_rdy low in FETCH or MEM stalls in place.
// Ports: clk, rst (sync, active-high); bus = fetch_sequencer_if.master (memory + decode side).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int BUS_W       = 8,
  parameter int INSTR_BYTES = INSTR_BYTES_DFLT,
  parameter int JMP_W       = 8
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  // The package default is reused when the instance matches it.
  localparam int BW = (INSTR_BYTES == INSTR_BYTES_DFLT) ? BEAT_W : beat_w_of(INSTR_BYTES);
  localparam int IW = BUS_W * INSTR_BYTES;
  localparam logic [BW-1:0] LAST_BEAT = BW'(INSTR_BYTES - 1);

  fetch_state_e    state;
  logic [BW-1:0]   beat;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] mem_addr_q;
  logic [IW-1:0]   instr_q;
  logic            mem_rd_q;
  logic            ls_phase_q;
  logic            instr_vld_q;

  fetch_pc_next #(
    .PC_W  (PC_W),
    .JMP_W (JMP_W),
    .STEP  (INSTR_BYTES)
  ) u_pc_next (
    .pc         (pc_q),
    .jmp_abs_en (bus.jmp_abs_en),
    .jmp_abs    (bus.jmp_abs),
    .jmp_rel_en (bus.jmp_rel_en),
    .jmp_rel    (bus.jmp_rel),
    .next_pc    (next_pc)
  );

  // Outputs are registered, so each transition also loads the strobes and
  // address that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      beat        <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b1;
      ls_phase_q  <= 1'b0;
      instr_vld_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.mem_rdy) begin
            for (int b = 0; b < INSTR_BYTES; b++) begin
              if (beat == BW'(b)) instr_q[b*BUS_W +: BUS_W] <= bus.mem_data;
            end
            if (beat == LAST_BEAT) begin
              state       <= EXEC;
              beat        <= '0;
              mem_rd_q    <= 1'b0;
              instr_vld_q <= 1'b1;
            end else begin
              beat       <= beat + BW'(1);
              // Address of the following beat; wraps past the top of memory.
              mem_addr_q <= pc_q + PC_W'(beat) + PC_W'(1);
            end
          end
        end
        EXEC: begin
          instr_vld_q <= 1'b0;
          pc_q        <= next_pc;
          if (bus.halt) begin
            state <= HALT;
          end else if (bus.exec_ls) begin
            // Jump target is already latched in pc_q; fetch resumes there after MEM.
            state      <= MEM;
            ls_phase_q <= 1'b1;
            mem_addr_q <= bus.ls_addr;
          end else begin
            state      <= FETCH;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= next_pc;
          end
        end
        MEM: begin
          if (bus.mem_rdy) begin
            state      <= FETCH;
            ls_phase_q <= 1'b0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= pc_q;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.ls_phase  = ls_phase_q;
  assign bus.instr     = instr_q;
  assign bus.instr_vld = instr_vld_q;
  assign bus.pc        = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: directed instruction stream with jumps,
// load/store phases, stalls, address wrap, halt and mid-fetch reset.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(16), .BUS_W(8), .INSTR_BYTES(2), .JMP_W(8)) bus ();

  fetch_sequencer #(.PC_W(16), .BUS_W(8), .INSTR_BYTES(2), .JMP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:65535];
  assign bus.mem_data = mem[bus.mem_addr];

  typedef struct { logic [15:0] instr; logic [15:0] pc; } ins_t;
  typedef struct { logic [15:0] addr; int len; } ls_t;

  ins_t        ins_q[$];
  ls_t         ls_q[$];
  logic [15:0] fetch_q[$];

  int tests = 0;
  int fails = 0;
  int ls_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Fetch monitor: accepted beats pop the address queue; stalled beats must hold it.
  always @(negedge clk) begin
    if (!rst && bus.mem_rd) begin
      if (fetch_q.size() == 0) begin
        check("unexpected fetch", 32'(bus.mem_rd), 32'd0);
      end else if (bus.mem_rdy) begin
        check("fetch addr", 32'(bus.mem_addr), 32'(fetch_q[0]));
        void'(fetch_q.pop_front());
      end else begin
        check("stalled fetch addr", 32'(bus.mem_addr), 32'(fetch_q[0]));
      end
    end
  end

  // Instruction monitor.
  always @(negedge clk) begin
    if (!rst && bus.instr_vld) begin
      if (ins_q.size() == 0) begin
        check("unexpected instr_vld", 32'(bus.instr_vld), 32'd0);
      end else begin
        check("instr", 32'(bus.instr), 32'(ins_q[0].instr));
        check("pc", 32'(bus.pc), 32'(ins_q[0].pc));
        check("mem_rd in exec", 32'(bus.mem_rd), 32'd0);
        void'(ins_q.pop_front());
      end
    end
  end

  // Load/store monitor: address every cycle, phase length when it ends.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ls_phase) begin
        if (ls_q.size() == 0) begin
          check("unexpected ls_phase", 32'(bus.ls_phase), 32'd0);
        end else begin
          check("ls addr", 32'(bus.mem_addr), 32'(ls_q[0].addr));
          check("mem_rd in ls", 32'(bus.mem_rd), 32'd0);
        end
        ls_len++;
      end else if (ls_len > 0) begin
        if (ls_q.size() > 0) begin
          check("ls length", 32'(ls_len), 32'(ls_q[0].len));
          void'(ls_q.pop_front());
        end
        ls_len = 0;
      end
    end
  end

  task automatic clear_ctl();
    bus.exec_ls    = 1'b0;
    bus.ls_addr    = '0;
    bus.jmp_rel_en = 1'b0;
    bus.jmp_rel    = '0;
    bus.jmp_abs_en = 1'b0;
    bus.jmp_abs    = '0;
    bus.halt       = 1'b0;
  endtask

  task automatic push_ins(input logic [15:0] ins, input logic [15:0] pc);
    ins_t e;
    e.instr = ins;
    e.pc    = pc;
    ins_q.push_back(e);
    fetch_q.push_back(pc);
    fetch_q.push_back(pc + 16'd1);
  endtask

  task automatic push_ls(input logic [15:0] addr, input int len);
    ls_t e;
    e.addr = addr;
    e.len  = len;
    ls_q.push_back(e);
  endtask

  // Holds controls until the EXEC cycle has been clocked, then clears them.
  // Returns at #1 after the EXEC exit edge; ncyc counts negedges up to instr_vld.
  task automatic run_instr(input logic ls, input logic [15:0] la, input logic re,
                           input logic [7:0] rv, input logic ae, input logic [15:0] av,
                           input logic h, output int ncyc);
    bus.exec_ls    = ls;
    bus.ls_addr    = la;
    bus.jmp_rel_en = re;
    bus.jmp_rel    = rv;
    bus.jmp_abs_en = ae;
    bus.jmp_abs    = av;
    bus.halt       = h;
    ncyc = 0;
    do begin
      @(negedge clk);
      ncyc++;
    end while (!bus.instr_vld && ncyc < 40);
    if (!bus.instr_vld) check("instr_vld timeout", 32'(bus.instr_vld), 32'd1);
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    mem[16'h0002] = 8'h78; mem[16'h0003] = 8'h56;
    mem[16'h0010] = 8'hBC; mem[16'h0011] = 8'h9A;
    mem[16'h000C] = 8'h11; mem[16'h000D] = 8'h22;
    mem[16'h8000] = 8'h44; mem[16'h8001] = 8'h33;
    mem[16'h8002] = 8'h66; mem[16'h8003] = 8'h55;
    mem[16'hFFFF] = 8'hEE;
    clear_ctl();
    bus.mem_rdy = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mem_addr", 32'(bus.mem_addr), 32'h0);
    check("reset mem_rd", 32'(bus.mem_rd), 32'h1);
    check("reset instr_vld", 32'(bus.instr_vld), 32'h0);
    check("reset ls_phase", 32'(bus.ls_phase), 32'h0);
    check("reset pc", 32'(bus.pc), 32'h0);
    check("reset instr", 32'(bus.instr), 32'h0);

    // Expected instruction stream (addresses, data and jump targets hand-computed).
    push_ins(16'h1234, 16'h0000);  // plain, next pc 2
    push_ins(16'h5678, 16'h0002);  // abs jump to 0x0010
    push_ins(16'h9ABC, 16'h0010);  // rel -4 -> 0x000C
    push_ins(16'h2211, 16'h000C);  // abs 0x8000 beats rel +5
    push_ins(16'h3344, 16'h8000);  // ls 0x9A00, 3 stall cycles
    push_ins(16'h5566, 16'h8002);  // ls 0x1234 plus abs jump to 0xFFFF
    push_ins(16'h34EE, 16'hFFFF);  // wraps to 0x0000, next pc 0x0001
    push_ins(16'h7812, 16'h0001);  // halt wins over exec_ls
    push_ls(16'h9A00, 4);
    push_ls(16'h1234, 1);

    @(posedge clk); #1; rst = 1'b0;

    run_instr(1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, n);
    check("first instr cycle", 32'(n), 32'd3);
    run_instr(1'b0, 16'h0, 1'b0, 8'h00, 1'b1, 16'h0010, 1'b0, n);
    run_instr(1'b0, 16'h0, 1'b1, 8'hFC, 1'b0, 16'h0, 1'b0, n);
    run_instr(1'b0, 16'h0, 1'b1, 8'h05, 1'b1, 16'h8000, 1'b0, n);
    run_instr(1'b1, 16'h9A00, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, n);
    bus.mem_rdy = 1'b0;              // MEM entered; hold off 3 cycles
    repeat (3) @(posedge clk);
    #1 bus.mem_rdy = 1'b1;
    run_instr(1'b1, 16'h1234, 1'b0, 8'h00, 1'b1, 16'hFFFF, 1'b0, n);
    repeat (2) @(posedge clk);       // MEM exit, then beat at 0xFFFF
    #1 bus.mem_rdy = 1'b0;           // stall beat at 0x0000 for 2 cycles
    repeat (2) @(posedge clk);
    #1 bus.mem_rdy = 1'b1;
    run_instr(1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, n);
    run_instr(1'b1, 16'h5555, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, n);

    // Halted: controls are ignored, pc and instr hold.
    bus.jmp_abs_en = 1'b1;
    bus.jmp_abs    = 16'h4444;
    bus.exec_ls    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt instr_vld", 32'(bus.instr_vld), 32'h0);
      check("halt mem_rd", 32'(bus.mem_rd), 32'h0);
      check("halt pc", 32'(bus.pc), 32'h0003);
      check("halt instr", 32'(bus.instr), 32'h7812);
    end
    clear_ctl();
    check("phase1 fetch drained", 32'(fetch_q.size()), 32'd0);
    check("phase1 instr drained", 32'(ins_q.size()), 32'd0);
    check("phase1 ls drained", 32'(ls_q.size()), 32'd0);

    // Reset after beat 0: partial instruction discarded.
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("halt reset pc", 32'(bus.pc), 32'h0);
    fetch_q.push_back(16'h0000);     // beat 0 accepted before reset lands
    push_ins(16'h1234, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midfetch reset instr", 32'(bus.instr), 32'h0);
    check("midfetch reset mem_addr", 32'(bus.mem_addr), 32'h0);
    check("midfetch reset instr_vld", 32'(bus.instr_vld), 32'h0);
    check("midfetch reset mem_rd", 32'(bus.mem_rd), 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    run_instr(1'b0, 16'h0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, n);
    check("post reset instr cycle", 32'(n), 32'd3);
    repeat (3) @(negedge clk);
    check("post reset halt pc", 32'(bus.pc), 32'h0002);
    check("phase2 fetch drained", 32'(fetch_q.size()), 32'd0);
    check("phase2 instr drained", 32'(ins_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
